// File: rtl/transpuesta_ctrl.sv
// rtl/transpuesta_ctrl.sv - fill/drain sequencer for the NxN single-bank transpose buffer
// Optional feature macro: TRANSPUESTA_CTRL_STATS_EN (adds blocks_done_o / stall_cycles_o).
module transpuesta_ctrl #(
    parameter int N  = 32,
    parameter int CW = $clog2(N)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          in_valid_i,
    output logic          in_ready_o,
    output logic          out_valid_o,
    input  logic          out_ready_i,
    output logic          out_last_o,
    output logic          load_o,
    output logic          unload_o,
    output logic [CW-1:0] row_idx_o,
    output logic [CW-1:0] col_idx_o,
    output logic          block_done_o
`ifdef TRANSPUESTA_CTRL_STATS_EN
    ,
    output logic [15:0]   blocks_done_o,
    output logic [15:0]   stall_cycles_o
`endif
);

    typedef enum logic {
        FILL  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    localparam logic [CW-1:0] IDX_LAST = CW'(N - 1);
    localparam logic [CW-1:0] IDX_PENULT = CW'(N - 2);

    state_t        state_q;
    logic          in_ready_q;
    logic          out_valid_q;
    logic          out_last_q;
    logic [CW-1:0] row_idx_q;
    logic [CW-1:0] col_idx_q;

    // Handshake-ready/valid come straight from flops so no input-to-output comb path exists.
    assign in_ready_o   = in_ready_q;
    assign out_valid_o  = out_valid_q;
    assign out_last_o   = out_last_q;
    assign row_idx_o    = row_idx_q;
    assign col_idx_o    = col_idx_q;
    assign load_o       = in_valid_i & in_ready_q & ~rst_i;
    assign unload_o     = out_valid_q & out_ready_i & ~rst_i;
    assign block_done_o = unload_o & out_last_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= FILL;
            row_idx_q   <= '0;
            col_idx_q   <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            case (state_q)
                FILL: begin
                    if (load_o) begin
                        if (row_idx_q == IDX_LAST) begin
                            row_idx_q   <= '0;
                            state_q     <= DRAIN;
                            in_ready_q  <= 1'b0;
                            out_valid_q <= 1'b1;
                        end else begin
                            row_idx_q <= row_idx_q + CW'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (unload_o) begin
                        if (col_idx_q == IDX_LAST) begin
                            col_idx_q   <= '0;
                            state_q     <= FILL;
                            in_ready_q  <= 1'b1;
                            out_valid_q <= 1'b0;
                            out_last_q  <= 1'b0;
                        end else begin
                            col_idx_q  <= col_idx_q + CW'(1);
                            out_last_q <= (col_idx_q == IDX_PENULT);
                        end
                    end
                end
                default: begin
                    state_q <= FILL;
                end
            endcase
        end
    end

`ifdef TRANSPUESTA_CTRL_STATS_EN
    logic [15:0] blocks_done_q;
    logic [15:0] blocks_done_d;
    logic [15:0] stall_cycles_q;
    logic [15:0] stall_cycles_d;

    always_comb begin
        blocks_done_d  = blocks_done_q;
        stall_cycles_d = stall_cycles_q;
        if (block_done_o) begin
            blocks_done_d = blocks_done_q + 16'd1;
        end
        if (state_q == DRAIN && !out_ready_i) begin
            stall_cycles_d = stall_cycles_q + 16'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            blocks_done_q  <= '0;
            stall_cycles_q <= '0;
        end else begin
            blocks_done_q  <= blocks_done_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign blocks_done_o  = blocks_done_q;
    assign stall_cycles_o = stall_cycles_q;
`endif

endmodule

// File: doc/transpuesta_ctrl.md
# transpuesta_ctrl

Sequencing controller for the 32×32 transpose buffer between the row-pass and column-pass 1-D DCT stages. It accepts N row vectors from the row-pass stage over a valid/ready handshake and drives the buffer's `load` strobe once per accepted row. It then presents N column vectors to the column-pass stage over a second valid/ready handshake, driving `unload` once per consumed column. The buffer is single-banked, so filling and draining never overlap.

## Interface
Parameters:
- `N`, 32: matrix dimension; rows per fill, columns per drain. Must match the buffer size; N ≥ 2.
- `CW`, `$clog2(N)`: index counter width.

Ports:
- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `in_valid`  in  1  row-pass stage presents a row on the buffer's x inputs.
- `in_ready`  out  1  controller accepts a row this cycle.
- `out_valid`  out  1  buffer y outputs hold a valid column.
- `out_ready`  in  1  column-pass stage consumes the column this cycle.
- `out_last`  out  1  current column is column N-1 of the block.
- `load`  out  1  to buffer; shift the presented row in.
- `unload`  out  1  to buffer; shift to the next column.
- `row_idx`  out  CW  rows accepted so far in the current fill.
- `col_idx`  out  CW  index of the column currently presented.
- `block_done`  out  1  one-cycle pulse on the cycle the last column is consumed.

## Operation
- Two-state FSM: FILL (reset state) and DRAIN.
- FILL:
  - `in_ready`=1 and `out_valid`=0.
  - `load` = `in_valid & in_ready`, combinational.
  - Each load increments `row_idx`.
  - A load with `row_idx`==N-1 clears `row_idx` and moves to DRAIN.
- DRAIN:
  - `in_ready`=0 and `out_valid`=1.
  - `unload` = `out_valid & out_ready`.
  - Each unload increments `col_idx`.
  - An unload with `col_idx`==N-1 asserts `block_done`, clears `col_idx` and returns to FILL.
- `out_last` = DRAIN & (`col_idx`==N-1).
- `load` and `unload` are never both 1.
- `in_valid` arriving during DRAIN is ignored; upstream holds it because `in_ready`=0.
- `out_ready` asserted during FILL has no effect.
- No gaps are required: back-to-back handshakes sustain one row or column per cycle.

## Timing
- Reset values, effective on the first edge with `rst`=1:
  - state FILL, `row_idx`=0, `col_idx`=0.
  - `out_valid`=0, `in_ready`=1, `out_last`=0, `block_done`=0.
  - `load` and `unload` are 0 while `rst`=1, because both are gated by `~rst`.
- Column 0 is valid on the buffer outputs on the cycle after the N-th load, which is the first DRAIN cycle, when `out_valid` rises.
- Column k+1 is valid on the cycle after the k-th unload.
- Minimum block period is 2N cycles: N fill plus N drain.
- Fill-to-drain and drain-to-fill turnarounds add zero bubble cycles. `in_ready` rises on the cycle after `block_done`.
- Reset mid-fill or mid-drain abandons the block: FSM returns to FILL with both indices 0. The buffer contents are cleared by the same `rst`.
- `in_ready` and `out_valid` depend only on registered state, not on `in_valid`/`out_ready`. This gives no combinational path from input handshake to output handshake.

## Configuration
- Macro `TRANSPUESTA_CTRL_STATS_EN`.
- Defined: adds two output ports, both reset to 0 and wrapping at 2^16:
  - `blocks_done` out 16: count of `block_done` pulses.
  - `stall_cycles` out 16: count of DRAIN cycles with `out_ready`=0.
- Undefined: neither port nor its counters exist. All other behaviour is identical.

## Test plan
- Reset, then `in_valid`=1 continuously, `out_ready`=1 continuously, N=32:
  - `load` is high on cycles 1–32 and `out_valid` rises on cycle 33.
  - `unload` is high on cycles 33–64, `block_done` pulses on cycle 64 and `in_ready` rises on cycle 65.
- Fill 32 rows where row r, column c holds 100·r+c:
  - The column-pass side sees column c as y_r = 100·r+c, for c = 0..31 in order.
  - `out_last` is high only with `col_idx`=31.
- Drain with `out_ready` toggling 1,0,1,0…: unload occurs only on ready cycles, the drain takes 63 cycles, and `stall_cycles` ends at 31 (STATS_EN).
- `in_valid` held high during DRAIN: zero loads occur and the buffer contents are unchanged; fill resumes exactly on the cycle after `block_done`.
- Assert `rst` after 17 loads:
  - `row_idx`=0, state FILL, `out_valid`=0.
  - The next block needs a full 32 loads before `out_valid`.
- Three back-to-back blocks: `blocks_done`=3 and `block_done` pulses are spaced exactly 64 cycles apart.
